// File: rtl/cmul_pkg.sv
// Shared definitions for the sequential complex multiplier: default width, FSM encoding,
// datapath op codes, complex slice helpers and saturation limits.
package cmul_pkg;

    localparam int CMUL_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S_RR = 3'd1,
        S_II = 3'd2,
        S_RI = 3'd3,
        S_IR = 3'd4,
        DONE = 3'd5
    } cmul_state_e;

    typedef enum logic [1:0] {
        OP_LOAD_RE = 2'd0,
        OP_SUB_RE  = 2'd1,
        OP_LOAD_IM = 2'd2,
        OP_ADD_IM  = 2'd3
    } mac_op_e;

    localparam logic signed [63:0] CMUL_SAT_MAX = (64'sd1 <<< (CMUL_W - 1)) - 64'sd1;
    localparam logic signed [63:0] CMUL_SAT_MIN = -(64'sd1 <<< (CMUL_W - 1));

    function automatic logic signed [63:0] sat_max(input int unsigned w);
        return (64'sd1 <<< (w - 32'd1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int unsigned w);
        return -(64'sd1 <<< (w - 32'd1));
    endfunction

    // Packed complex is {Re, Im}; helpers support component widths up to 32 bits.
    function automatic logic [31:0] cplx_re(input logic [63:0] x, input int unsigned w);
        return 32'(x >> w);
    endfunction

    function automatic logic [31:0] cplx_im(input logic [63:0] x);
        return 32'(x);
    endfunction

endpackage

// File: rtl/cmul_seq_ctrl_if.sv
// Operand/result handshake bundle of the sequential complex multiplier.
// The sat signal exists only when CMUL_SAT_EN is defined.
interface cmul_seq_ctrl_if import cmul_pkg::*; #(parameter int W = CMUL_W) ();

    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] a;
    logic [2*W-1:0] b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] c;
    logic           busy;
`ifdef CMUL_SAT_EN
    logic           sat;

    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, c, busy, sat);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, c, busy, sat);
`else
    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, c, busy);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, c, busy);
`endif

endinterface

// File: rtl/cmul_mac_dp.sv
// Shared multiply-accumulate datapath: one signed W x W multiplier feeding a
// load/add/sub stage into the 2W+1-bit real and imaginary accumulators.
module cmul_mac_dp import cmul_pkg::*; #(
    parameter int W = CMUL_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2*W-1:0]      a_op,
    input  logic [2*W-1:0]      b_op,
    input  logic                mac_en,
    input  mac_op_e             mac_op,
    output logic signed [2*W:0] acc_re,
    output logic signed [2*W:0] acc_next
);

    logic signed [W-1:0]   a_re_s, a_im_s, b_re_s, b_im_s;
    logic signed [W-1:0]   mul_a_s, mul_b_s;
    logic signed [2*W-1:0] prod_s;
    logic signed [2*W:0]   prod_ext_s;
    logic signed [2*W:0]   acc_next_s;
    logic signed [2*W:0]   acc_re_r, acc_im_r;

    assign a_re_s = W'(cplx_re(64'(a_op), W));
    assign a_im_s = W'(cplx_im(64'(a_op)));
    assign b_re_s = W'(cplx_re(64'(b_op), W));
    assign b_im_s = W'(cplx_im(64'(b_op)));

    // Steer the operand pair for the current partial product
    always_comb begin
        mul_a_s = a_re_s;
        mul_b_s = b_re_s;
        case (mac_op)
            OP_LOAD_RE: begin mul_a_s = a_re_s; mul_b_s = b_re_s; end
            OP_SUB_RE:  begin mul_a_s = a_im_s; mul_b_s = b_im_s; end
            OP_LOAD_IM: begin mul_a_s = a_re_s; mul_b_s = b_im_s; end
            OP_ADD_IM:  begin mul_a_s = a_im_s; mul_b_s = b_re_s; end
            default:    begin mul_a_s = a_re_s; mul_b_s = b_re_s; end
        endcase
    end

    // Full-width signed product; (-2^(W-1))^2 still fits in 2W signed bits
    assign prod_s = $signed({{W{mul_a_s[W-1]}}, mul_a_s}) * $signed({{W{mul_b_s[W-1]}}, mul_b_s});
    assign prod_ext_s = $signed({prod_s[2*W-1], prod_s});

    // Load/add/sub select producing the next accumulator value
    always_comb begin
        acc_next_s = prod_ext_s;
        case (mac_op)
            OP_LOAD_RE: acc_next_s = prod_ext_s;
            OP_SUB_RE:  acc_next_s = acc_re_r - prod_ext_s;
            OP_LOAD_IM: acc_next_s = prod_ext_s;
            OP_ADD_IM:  acc_next_s = acc_im_r + prod_ext_s;
            default:    acc_next_s = prod_ext_s;
        endcase
    end

    // Accumulator update for the active component
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_re_r <= {(2*W+1){1'b0}};
            acc_im_r <= {(2*W+1){1'b0}};
        end else if (mac_en) begin
            case (mac_op)
                OP_LOAD_RE, OP_SUB_RE: acc_re_r <= acc_next_s;
                OP_LOAD_IM, OP_ADD_IM: acc_im_r <= acc_next_s;
                default:               acc_re_r <= acc_re_r;
            endcase
        end else begin
            acc_re_r <= acc_re_r;
            acc_im_r <= acc_im_r;
        end
    end

    assign acc_re   = acc_re_r;
    assign acc_next = acc_next_s;

endmodule

// File: rtl/cmul_seq_ctrl.sv
// Sequential complex multiplier c = a*b using one shared multiplier over four cycles.
// Define CMUL_SAT_EN to clamp result components and expose the registered sat flag.
module cmul_seq_ctrl import cmul_pkg::*; #(
    parameter int W = CMUL_W
) (
    input  logic           clk,
    input  logic           rst,
    cmul_seq_ctrl_if.slave bus
);

    cmul_state_e         state_r, state_s;
    logic [2*W-1:0]      a_r, b_r, c_r;
    logic                in_ready_s, accept_s;
    logic                mac_en_s;
    mac_op_e             mac_op_s;
    logic signed [2*W:0] acc_re_s, acc_next_s;
    logic [W-1:0]        c_re_s, c_im_s;

    assign in_ready_s = (state_r == IDLE) || ((state_r == DONE) && bus.out_ready);
    assign accept_s   = bus.in_valid && in_ready_s;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and per-cycle datapath op
    always_comb begin
        state_s  = state_r;
        mac_en_s = 1'b0;
        mac_op_s = OP_LOAD_RE;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = S_RR;
                else          state_s = IDLE;
            end
            S_RR: begin state_s = S_II; mac_en_s = 1'b1; mac_op_s = OP_LOAD_RE; end
            S_II: begin state_s = S_RI; mac_en_s = 1'b1; mac_op_s = OP_SUB_RE;  end
            S_RI: begin state_s = S_IR; mac_en_s = 1'b1; mac_op_s = OP_LOAD_IM; end
            S_IR: begin state_s = DONE; mac_en_s = 1'b1; mac_op_s = OP_ADD_IM;  end
            DONE: begin
                if (accept_s)           state_s = S_RR;
                else if (bus.out_ready) state_s = IDLE;
                else                    state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Operand capture; ports are not looked at again until the next accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r <= {(2*W){1'b0}};
            b_r <= {(2*W){1'b0}};
        end else if (accept_s) begin
            a_r <= bus.a;
            b_r <= bus.b;
        end else begin
            a_r <= a_r;
            b_r <= b_r;
        end
    end

    cmul_mac_dp #(.W(W)) u_dp (
        .clk      (clk),
        .rst      (rst),
        .a_op     (a_r),
        .b_op     (b_r),
        .mac_en   (mac_en_s),
        .mac_op   (mac_op_s),
        .acc_re   (acc_re_s),
        .acc_next (acc_next_s)
    );

`ifdef CMUL_SAT_EN
    localparam logic signed [2*W:0] SAT_HI = (2*W+1)'(sat_max(W));
    localparam logic signed [2*W:0] SAT_LO = (2*W+1)'(sat_min(W));

    logic sat_re_s, sat_im_s, sat_r;

    // Returns {clamped, value}
    function automatic logic [W:0] clamp(input logic signed [2*W:0] x);
        if (x > SAT_HI)      return {1'b1, SAT_HI[W-1:0]};
        else if (x < SAT_LO) return {1'b1, SAT_LO[W-1:0]};
        else                 return {1'b0, x[W-1:0]};
    endfunction

    assign {sat_re_s, c_re_s} = clamp(acc_re_s);
    assign {sat_im_s, c_im_s} = clamp(acc_next_s);

    // Saturation flag travels with c
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_r <= 1'b0;
        end else if (state_r == S_IR) begin
            sat_r <= sat_re_s | sat_im_s;
        end else begin
            sat_r <= sat_r;
        end
    end

    assign bus.sat = sat_r;
`else
    assign c_re_s = W'(acc_re_s);
    assign c_im_s = W'(acc_next_s);
`endif

    // Result register; the imaginary part is taken from the final accumulate in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_r <= {(2*W){1'b0}};
        end else if (state_r == S_IR) begin
            c_r <= {c_re_s, c_im_s};
        end else begin
            c_r <= c_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (state_r == DONE);
    assign bus.busy      = (state_r != IDLE);
    assign bus.c         = c_r;

endmodule

// File: doc/cmul_seq_ctrl.md
Name: cmul_seq_ctrl

Overview:
Sequential complex multiplier controller. It time-shares one signed real multiplier and one add/sub unit over four cycles to compute c = a*b on packed complex operands. It sits between an upstream producer and a downstream consumer, with valid/ready handshakes on both sides. It is the area-reduced alternative to the fully combinational four-multiplier complex multiplier.

Parameters:
W, 16, bit width of each real and imaginary component (two's complement)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept an operand pair this cycle
a  in  2W  operand A, packed complex: Re = [2W-1:W], Im = [W-1:0]
b  in  2W  operand B, same packing as a
out_valid  out  1  result c valid
out_ready  in  1  consumer accepts c this cycle
c  out  2W  result, same packing as a
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; out_valid=0; busy=0; c=0.
  - Operand registers and accumulators cleared to 0.
  - A transaction in flight is aborted, with no output.
- States: IDLE, S_RR, S_II, S_RI, S_IR, DONE.
- Accept:
  - Occurs on an edge with in_valid && in_ready.
  - Latches a and b into internal registers; next state is S_RR.
  - Input ports are not sampled again until the next accept.
- Compute, one real product per cycle:
  - S_RR: acc_re = Re(a)*Re(b)
  - S_II: acc_re = acc_re - Im(a)*Im(b)
  - S_RI: acc_im = Re(a)*Im(b)
  - S_IR: acc_im = acc_im + Im(a)*Re(b), then c is registered from the accumulators.
- Accumulators are 2W+1 bits signed; products are sign-extended.
- Output narrowing (default): c components are the low W bits of the accumulators (two's-complement wrap). This matches W-bit complex multiply semantics.
- DONE:
  - out_valid=1; c is held stable until out_ready=1.
  - out_valid may not drop without out_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Back-to-back: result handoff and a new accept on the same edge go directly to S_RR.
  - Throughput is one result per 5 cycles; latency from the accept edge to out_valid is 4 edges.
- DONE with out_ready=1 and in_valid=0 goes to IDLE; out_valid falls on that edge.
- c keeps its last value after handoff and changes only on the S_IR edge.
- busy=1 in S_RR..DONE.
- in_valid while busy (and not accepted) is ignored; the upstream producer must hold it.
- Boundary: the most-negative value (-2^(W-1)) is legal on all components. (-2^(W-1))^2 is represented exactly in the 2W+1-bit accumulator.

Optional Feature:
CMUL_SAT_EN
- Defined:
  - Each component of c is clamped to [-2^(W-1), 2^(W-1)-1] instead of wrapping.
  - Extra output port sat (1 bit) is registered with c: high if either component clamped, reset 0.
- Undefined: wrap behaviour as above; no sat port.

Decomposition:
- Package cmul_pkg:
  - default W
  - state encoding constants (IDLE=0 .. DONE=5)
  - complex Re/Im slice helpers matching the packing above
  - signed saturation limit constants
- One sub-module: cmul_mac_dp.
  - Contains the single signed W x W multiplier, add/sub/load select, and the 2W+1-bit accumulator.
  - Driven by op selects from the controller FSM.

Test Plan (W=16 unless noted):
1. a=(-10,5), b=(3,-8), out_ready=1 -> out_valid exactly 4 edges after accept, c=(10,95), busy high for those cycles.
2. a=(6,3), b=(2,-6) then a=(2,8), b=(0,2), in_valid held, out_ready=1:
   - Back-to-back accept on the DONE edge.
   - c=(30,-30), then c=(-16,4) 5 cycles later.
3. Backpressure: a=(4,1), b=(-2,-7), out_ready=0 for 6 cycles -> c=(-1,-30) held stable with out_valid=1 throughout; in_ready=0; released on the first out_ready edge.
4. Reset mid-operation: assert rst in S_II -> out_valid=0 and c=0 immediately (async); after release, the next transaction a=(1,1), b=(1,-1) gives c=(2,0).
5. W=8, a=(100,0), b=(2,0):
   - Without CMUL_SAT_EN: c=(-56,0).
   - With CMUL_SAT_EN: c=(127,0), sat=1.
   - Then a=(-128,0), b=(-128,0): c=(0,0) wrap, or c=(127,0) with sat=1.
6. in_valid pulsed while busy -> ignored; the next result corresponds only to the accepted operands.
